// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: width-generic Gray conversions and
// configuration limits checked at elaboration by the FIFO controllers.
package fifo_pkg;

    localparam int unsigned MIN_ADDR_SIZE   = 2;
    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MAX_PTR_W       = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_word_t;

    // Callers zero-extend into ptr_word_t and truncate the result to their width.
    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int i = 1; i < MAX_PTR_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync_nstage.sv
// N-flop bus synchronizer for Gray-coded pointers crossing clock domains.
// Also exposes the value the output stage will load at the next edge.
module ptr_sync_nstage #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_q_nxt
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q     = r_stage[STAGES-1];
    assign o_q_nxt = r_stage[STAGES-2];

endmodule

// File: rtl/fifo_rd_fwft_ctrl.sv
// Read-domain controller of the dual-clock FIFO: first-word-fall-through output
// through a 2-entry register buffer fed by a 1-cycle-latency memory port.
module fifo_rd_fwft_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_SIZE   = 12,
    parameter int unsigned ADDR_SIZE   = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 rclk,
    input  logic                 wrst,
    input  logic [ADDR_SIZE:0]   wptr_gray,
    output logic [ADDR_SIZE:0]   rptr_gray,
    output logic                 mem_ren,
    output logic [ADDR_SIZE-1:0] raddr,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    input  logic [ADDR_SIZE:0]   ae_thresh,
    output logic [ADDR_SIZE:0]   rlevel,
    output logic                 rempty,
    output logic                 ralmost_empty
);

    localparam int unsigned PW = ADDR_SIZE + 1;

    if (ADDR_SIZE < MIN_ADDR_SIZE) begin : g_bad_addr_size
        $error("fifo_rd_fwft_ctrl: ADDR_SIZE must be at least 2");
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
        $error("fifo_rd_fwft_ctrl: SYNC_STAGES must be at least 2");
    end

    logic [PW-1:0]        w_wptr_s, w_wptr_s_nxt, w_wbin_s, w_wbin_s_nxt;
    logic [PW-1:0]        w_rpop_nxt, w_level_nxt;
    logic                 w_pop, w_avail, w_room, w_ren;
    logic [1:0]           w_cnt_kept, w_ob_cnt_nxt;
    logic [2:0]           w_occupancy;
    logic [DATA_SIZE-1:0] w_ob_data_nxt [2];

    logic [PW-1:0]        r_rbin, r_rpop, r_rptr_gray, r_rlevel;
    logic                 r_inflight, r_rd_valid, r_rempty, r_ralmost_empty;
    logic [1:0]           r_ob_cnt;
    logic [DATA_SIZE-1:0] r_ob_data [2];

    ptr_sync_nstage #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .i_clk   (rclk),
        .i_rst_n (wrst),
        .i_d     (wptr_gray),
        .o_q     (w_wptr_s),
        .o_q_nxt (w_wptr_s_nxt)
    );

    assign w_wbin_s     = PW'(gray2bin(ptr_word_t'(w_wptr_s)));
    assign w_wbin_s_nxt = PW'(gray2bin(ptr_word_t'(w_wptr_s_nxt)));

    assign w_pop       = r_rd_valid & rd_ready;
    assign w_avail     = (w_wbin_s - r_rbin) != '0;
    // Buffer entries committed after this edge if nothing new is issued.
    assign w_occupancy = {1'b0, r_ob_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_room      = w_occupancy < 3'd2;
    assign w_ren       = w_avail & w_room;

    assign w_rpop_nxt  = r_rpop + PW'(w_pop);
    assign w_level_nxt = w_wbin_s_nxt - w_rpop_nxt;
    assign w_cnt_kept  = r_ob_cnt - {1'b0, w_pop};

    always_comb begin
        w_ob_data_nxt = r_ob_data;
        if (w_pop) begin
            w_ob_data_nxt[0] = r_ob_data[1];
        end
        if (r_inflight) begin
            w_ob_data_nxt[w_cnt_kept[0]] = mem_rdata;
        end
        w_ob_cnt_nxt = w_cnt_kept + {1'b0, r_inflight};
    end

    always_ff @(posedge rclk or negedge wrst) begin
        if (!wrst) begin
            r_rbin          <= '0;
            r_rpop          <= '0;
            r_inflight      <= 1'b0;
            r_ob_cnt        <= '0;
            r_ob_data[0]    <= '0;
            r_ob_data[1]    <= '0;
            r_rd_valid      <= 1'b0;
            r_rptr_gray     <= '0;
            r_rlevel        <= '0;
            r_rempty        <= 1'b1;
            r_ralmost_empty <= 1'b1;
        end else begin
            r_rbin          <= r_rbin + PW'(w_ren);
            r_rpop          <= w_rpop_nxt;
            r_inflight      <= w_ren;
            r_ob_cnt        <= w_ob_cnt_nxt;
            r_ob_data       <= w_ob_data_nxt;
            r_rd_valid      <= w_ob_cnt_nxt != 2'd0;
            r_rptr_gray     <= PW'(bin2gray(ptr_word_t'(w_rpop_nxt)));
            r_rlevel        <= w_level_nxt;
            r_rempty        <= w_level_nxt == '0;
            r_ralmost_empty <= w_level_nxt <= ae_thresh;
        end
    end

    assign rptr_gray     = r_rptr_gray;
    assign mem_ren       = w_ren;
    assign raddr         = r_rbin[ADDR_SIZE-1:0];
    assign rd_data       = r_ob_data[0];
    assign rd_valid      = r_rd_valid;
    assign rlevel        = r_rlevel;
    assign rempty        = r_rempty;
    assign ralmost_empty = r_ralmost_empty;

endmodule

// File: tb/tb_fifo_rd_fwft_ctrl.sv
// Bench for fifo_rd_fwft_ctrl: random write-side bursts and consumer stalls,
// words tracked in a scoreboard queue and checked on every accepted handshake.
module tb_fifo_rd_fwft_ctrl;

    localparam int unsigned DS    = 12;
    localparam int unsigned AS    = 4;
    localparam int unsigned DEPTH = 16;

    logic          rclk, wrst;
    logic [AS:0]   wptr_gray, rptr_gray, ae_thresh, rlevel;
    logic          mem_ren, rd_valid, rd_ready, rempty, ralmost_empty;
    logic [AS-1:0] raddr;
    logic [DS-1:0] mem_rdata, rd_data;
    logic [DS-1:0] mem [DEPTH];

    fifo_rd_fwft_ctrl #(
        .DATA_SIZE   (DS),
        .ADDR_SIZE   (AS),
        .SYNC_STAGES (2)
    ) dut (
        .rclk          (rclk),
        .wrst          (wrst),
        .wptr_gray     (wptr_gray),
        .rptr_gray     (rptr_gray),
        .mem_ren       (mem_ren),
        .raddr         (raddr),
        .mem_rdata     (mem_rdata),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .ae_thresh     (ae_thresh),
        .rlevel        (rlevel),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // External 1-cycle-latency memory.
    always @(posedge rclk) if (mem_ren) mem_rdata <= mem[raddr];

    int          total, bad;
    logic [DS-1:0] sb [$];
    int unsigned wbin, popped, pending, burst_max;
    bit          burst_rand;
    int          rd_mode;
    int          cyc, last_pop;
    bit          stream_chk, have_last;

    always @(posedge rclk) cyc <= cyc + 1;

    function automatic logic [AS:0] gray5(input int unsigned b);
        logic [AS:0] x;
        x = b[AS:0];
        return x ^ (x >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted word.
    initial begin
        logic [DS-1:0] exp_d;
        forever begin
            @(negedge rclk);
            if (wrst === 1'b1) begin
                if (rd_valid && rd_ready) begin
                    exp_d = (sb.size() > 0) ? sb.pop_front() : 'x;
                    check("pop data", 32'(rd_data), 32'(exp_d));
                    popped++;
                    if (stream_chk && have_last) check("stream gap", cyc - last_pop, 1);
                    last_pop  = cyc;
                    have_last = 1'b1;
                end
                check("rempty vs rlevel", 32'(rempty), 32'(rlevel == 0));
                check("ralmost vs rlevel", 32'(ralmost_empty), 32'(rlevel <= ae_thresh));
                check("rlevel range", 32'(rlevel <= DEPTH), 1);
            end
        end
    end

    task automatic step();
        int unsigned n, r;
        @(posedge rclk);
        #1;
        case (rd_mode)
            0:       rd_ready = 1'b0;
            1:       rd_ready = 1'b1;
            2:       rd_ready = ~rd_ready;
            default: rd_ready = 1'($urandom_range(0, 1));
        endcase
        n = (burst_rand && burst_max > 1) ? $urandom_range(1, burst_max) : burst_max;
        for (int k = 0; k < int'(n); k++) begin
            if (pending > 0 && (wbin - popped) < DEPTH) begin
                r = $urandom;
                mem[wbin[AS-1:0]] = {r[7:0], wbin[3:0]};
                sb.push_back({r[7:0], wbin[3:0]});
                wbin++;
                pending--;
            end
        end
        wptr_gray = gray5(wbin);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((sb.size() != 0 || pending != 0) && n < limit) begin
            step();
            n++;
        end
        check("drain in time", 32'(sb.size() == 0 && pending == 0), 1);
    endtask

    task automatic quiesce();
        repeat (5) step();
        #1;
        check("rlevel model", 32'(rlevel), wbin - popped);
        check("rempty model", 32'(rempty), 32'(wbin == popped));
        check("rptr_gray model", 32'(rptr_gray), 32'(gray5(popped)));
        if (rd_mode == 0) check("rd_valid held", 32'(rd_valid), 32'(wbin != popped));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rd_valid"}, 32'(rd_valid), 0);
        check({tag, " rd_data"}, 32'(rd_data), 0);
        check({tag, " rempty"}, 32'(rempty), 1);
        check({tag, " ralmost"}, 32'(ralmost_empty), 1);
        check({tag, " rlevel"}, 32'(rlevel), 0);
        check({tag, " rptr_gray"}, 32'(rptr_gray), 0);
        check({tag, " mem_ren"}, 32'(mem_ren), 0);
        check({tag, " raddr"}, 32'(raddr), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; wbin = 0; popped = 0; pending = 0;
        burst_max = 0; burst_rand = 0; rd_mode = 0; cyc = 0;
        stream_chk = 0; have_last = 0; last_pop = 0;
        wrst = 1'b0; rd_ready = 1'b0; wptr_gray = '0; ae_thresh = 5'd3; mem_rdata = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Reset held while the write pointer toggles.
        repeat (6) begin
            @(posedge rclk);
            #1 wptr_gray = 5'($urandom);
            #1 check_reset_outputs("reset");
        end
        wptr_gray = '0;
        @(posedge rclk);
        #3 wrst = 1'b1;
        step();

        // Single word, consumer stalled.
        @(posedge rclk);
        #1;
        mem[0] = 12'hABC;
        sb.push_back(12'hABC);
        wbin = 1;
        wptr_gray = gray5(wbin);
        step(); #1;
        check("single e1 mem_ren", 32'(mem_ren), 0);
        check("single e1 rd_valid", 32'(rd_valid), 0);
        step(); #1;
        check("single e2 mem_ren", 32'(mem_ren), 1);
        check("single e2 rlevel", 32'(rlevel), 1);
        step(); #1;
        check("single e3 mem_ren", 32'(mem_ren), 0);
        check("single e3 rd_valid", 32'(rd_valid), 0);
        step(); #1;
        check("single e4 rd_valid", 32'(rd_valid), 1);
        check("single e4 rd_data", 32'(rd_data), 32'h0ABC);
        check("single e4 rlevel", 32'(rlevel), 1);
        check("single e4 rptr_gray", 32'(rptr_gray), 0);
        check("single e4 rempty", 32'(rempty), 0);
        rd_mode = 1;
        step();
        step(); #1;
        check("single pop rptr_gray", 32'(rptr_gray), 1);
        check("single pop rempty", 32'(rempty), 1);
        check("single pop rd_valid", 32'(rd_valid), 0);

        // Full streaming: pointer jumps to 16, one word per cycle.
        stream_chk = 1; have_last = 0;
        pending = 15; burst_max = 15; burst_rand = 0;
        drain(100);
        stream_chk = 0;
        quiesce();
        check("stream final rptr_gray", 32'(rptr_gray), 32'b11000);

        // Back-pressure with alternating ready.
        rd_mode = 2; pending = 16; burst_max = 16;
        drain(200);
        rd_mode = 1;
        quiesce();

        // Random bursts and random ready.
        rd_mode = 3; pending = 200; burst_max = 3; burst_rand = 1;
        drain(3000);
        rd_mode = 1;
        quiesce();

        // Wrap: bring pointers to 30, then 4 words across the boundary.
        pending = (30 + 32 - (wbin % 32)) % 32; burst_max = 4;
        drain(400);
        quiesce();
        check("wrap start pointer", wbin % 32, 30);
        rd_mode = 0; pending = 4; burst_max = 4; burst_rand = 0;
        step();
        quiesce();
        rd_mode = 1;
        drain(50);
        quiesce();

        // Reset asserted mid-stream while reads are in flight.
        pending = 8; burst_max = 8;
        repeat (6) step();
        #2 wrst = 1'b0;
        #1 check_reset_outputs("midreset");
        sb.delete();
        wbin = 0; popped = 0; pending = 0; wptr_gray = '0;
        @(posedge rclk);
        #3 wrst = 1'b1;
        repeat (4) begin
            step(); #1;
            check("post reset rd_valid", 32'(rd_valid), 0);
            check("post reset rlevel", 32'(rlevel), 0);
        end

        // Recovery after reset.
        rd_mode = 3; pending = 40; burst_max = 2; burst_rand = 1;
        drain(1000);
        rd_mode = 1;
        quiesce();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
